// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order branch prediction queue resolving outcomes, driving BHT updates, flush/redirect and perf counters
// Ports: i_clk/i_arst_n clock and async active-low reset; i_en pipeline advance;
//   i_fetch_* push a predicted branch; i_resolve_* resolve the oldest in-flight branch;
//   o_queue_full stall request; o_bht_* history table update; o_flush/o_redirect_pc misprediction recovery;
//   o_branch_count/o_mispredict_count saturating counters; o_protocol_err sticky resolve-on-empty flag.
module branch_resolve_unit #(
  parameter int LOWER = 5,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_en,
  input  logic             i_fetch_valid,
  input  logic             i_fetch_is_branch,
  input  logic [PC_W-1:0]  i_fetch_pc,
  input  logic             i_fetch_prediction,
  input  logic             i_resolve_valid,
  input  logic             i_resolve_taken,
  input  logic             i_resolve_jump,
  input  logic [PC_W-1:0]  i_resolve_target,
  output logic             o_queue_full,
  output logic             o_bht_en,
  output logic [LOWER-1:0] o_bht_write_addr,
  output logic             o_bht_was_taken,
  output logic             o_bht_jumped,
  output logic             o_flush,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic [31:0]      o_branch_count,
  output logic [31:0]      o_mispredict_count,
  output logic             o_protocol_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] r_pc [DEPTH];
  logic [DEPTH-1:0] r_pred;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_pop, w_push, w_actual, w_mispredict;
  logic [PC_W-1:0] w_head_pc;
  assign o_queue_full = r_count == CW'(DEPTH);
  assign w_pop = i_en & i_resolve_valid & (r_count != '0);
  // a full queue can still accept a push when the head leaves in the same cycle
  assign w_push = i_en & i_fetch_valid & i_fetch_is_branch & (!o_queue_full | w_pop);
  assign w_head_pc = r_pc[r_rd_ptr];
  assign w_actual = i_resolve_taken | i_resolve_jump;
  assign w_mispredict = w_pop & (w_actual != r_pred[r_rd_ptr]);
  // storage needs no reset: entries are only read once counted in
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr] <= i_fetch_pc;
      r_pred[r_wr_ptr] <= i_fetch_prediction;
    end
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      o_bht_en <= 1'b0;
      o_bht_write_addr <= '0;
      o_bht_was_taken <= 1'b0;
      o_bht_jumped <= 1'b0;
      o_flush <= 1'b0;
      o_redirect_pc <= '0;
      o_branch_count <= '0;
      o_mispredict_count <= '0;
      o_protocol_err <= 1'b0;
    end else begin
      o_bht_en <= w_pop;
      o_flush <= w_mispredict;
      if (w_pop) begin
        o_bht_write_addr <= w_head_pc[LOWER-1:0];
        o_bht_was_taken <= i_resolve_taken;
        o_bht_jumped <= i_resolve_jump;
        o_redirect_pc <= w_actual ? i_resolve_target : w_head_pc + PC_W'(4);
        o_branch_count <= (&o_branch_count) ? o_branch_count : o_branch_count + 32'd1;
      end
      if (w_mispredict)
        o_mispredict_count <= (&o_mispredict_count) ? o_mispredict_count : o_mispredict_count + 32'd1;
      if (i_en & i_resolve_valid & (r_count == '0))
        o_protocol_err <= 1'b1;
      // younger entries (and a same-cycle push) are wrong-path after a mispredict
      if (w_mispredict) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en, fv, fb, fpred, rv, rt, rj;
  logic [31:0] fpc, rtgt;
  logic queue_full, bht_en, was_taken, jumped, flush, perr;
  logic [4:0] waddr;
  logic [31:0] redirect, bc, mc;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_bc, exp_mc;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_en(en),
    .i_fetch_valid(fv), .i_fetch_is_branch(fb), .i_fetch_pc(fpc), .i_fetch_prediction(fpred),
    .i_resolve_valid(rv), .i_resolve_taken(rt), .i_resolve_jump(rj), .i_resolve_target(rtgt),
    .o_queue_full(queue_full), .o_bht_en(bht_en), .o_bht_write_addr(waddr),
    .o_bht_was_taken(was_taken), .o_bht_jumped(jumped), .o_flush(flush),
    .o_redirect_pc(redirect), .o_branch_count(bc), .o_mispredict_count(mc),
    .o_protocol_err(perr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle();
    en = 1'b1; fv = 1'b0; fb = 1'b0; fpc = '0; fpred = 1'b0;
    rv = 1'b0; rt = 1'b0; rj = 1'b0; rtgt = '0;
  endtask

  task automatic push_br(input logic [31:0] pc, input logic p);
    fv = 1'b1; fb = 1'b1; fpc = pc; fpred = p;
    @(posedge clk); #1;
    fv = 1'b0; fb = 1'b0;
  endtask

  task automatic resolve_br(input logic t, input logic j, input logic [31:0] tgt);
    rv = 1'b1; rt = t; rj = j; rtgt = tgt;
    @(posedge clk); #1;
    rv = 1'b0; rt = 1'b0; rj = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    arst_n = 1'b0;
    #2;
    tests++;
    if ({queue_full, bht_en, waddr, was_taken, jumped, flush, redirect, bc, mc, perr} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got full=%0b en=%0b addr=%h flush=%0b rd=%h bc=%h mc=%h perr=%0b exp all 0",
               queue_full, bht_en, waddr, flush, redirect, bc, mc, perr);
    end
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    exp_bc = 0; exp_mc = 0;
  endtask

  task automatic test_correct();
    push_br(32'h10, 1'b1);
    resolve_br(1'b1, 1'b0, 32'h40);
    exp_bc++;
    tests++; if (bht_en !== 1'b1) begin fails++; $display("FAIL correct_bht_en got %0b exp 1", bht_en); end
    tests++; if (waddr !== 5'h10) begin fails++; $display("FAIL correct_addr got %h exp 10", waddr); end
    tests++; if (was_taken !== 1'b1) begin fails++; $display("FAIL correct_taken got %0b exp 1", was_taken); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL correct_flush got %0b exp 0", flush); end
    tests++; if (bc !== 32'd1) begin fails++; $display("FAIL correct_bc got %0d exp 1", bc); end
    tests++; if (mc !== 32'd0) begin fails++; $display("FAIL correct_mc got %0d exp 0", mc); end
    @(posedge clk); #1;
    tests++; if (bht_en !== 1'b0) begin fails++; $display("FAIL correct_bht_pulse got %0b exp 0", bht_en); end
    push_br(32'h2C, 1'b0);
    resolve_br(1'b0, 1'b0, 32'h80);
    exp_bc++;
    tests++; if ({bht_en, waddr, was_taken, flush} !== {1'b1, 5'h0C, 1'b0, 1'b0}) begin
      fails++; $display("FAIL correct_nt got en=%0b addr=%h tk=%0b fl=%0b exp en=1 addr=0c tk=0 fl=0", bht_en, waddr, was_taken, flush);
    end
    tests++; if (bc !== 32'd2) begin fails++; $display("FAIL correct_bc2 got %0d exp 2", bc); end
  endtask

  task automatic test_not_taken();
    push_br(32'h24, 1'b1);
    resolve_br(1'b0, 1'b0, 32'h99);
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL nt_flush got %0b exp 1", flush); end
    tests++; if (redirect !== 32'h28) begin fails++; $display("FAIL nt_redirect got %h exp 28", redirect); end
    tests++; if (waddr !== 5'h04) begin fails++; $display("FAIL nt_addr got %h exp 04", waddr); end
    tests++; if (mc !== 32'd1) begin fails++; $display("FAIL nt_mc got %0d exp 1", mc); end
    tests++; if (bc !== 32'd3) begin fails++; $display("FAIL nt_bc got %0d exp 3", bc); end
    arst_n = 1'b0;
    #1;
    tests++; if ({flush, bht_en, bc, mc, redirect} !== '0) begin
      fails++; $display("FAIL midflush_reset got fl=%0b en=%0b bc=%0d mc=%0d rd=%h exp all 0", flush, bht_en, bc, mc, redirect);
    end
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if ({flush, bht_en} !== 2'b00) begin fails++; $display("FAIL midflush_replay got fl=%0b en=%0b exp 0 0", flush, bht_en); end
    exp_bc = 0; exp_mc = 0;
  endtask

  task automatic test_full_wrap();
    logic [31:0] pc;
    push_br(32'h200, 1'b1);
    resolve_br(1'b1, 1'b0, 32'h0);
    exp_bc++;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) push_br(32'h100 + 32'(r) * 32'h10 + 32'(k) * 4, 1'b1);
      tests++; if (queue_full !== 1'b1) begin fails++; $display("FAIL wrap_full r%0d got %0b exp 1", r, queue_full); end
      push_br(32'h3F0, 1'b1);
      tests++; if (queue_full !== 1'b1) begin fails++; $display("FAIL wrap_drop r%0d got %0b exp 1", r, queue_full); end
      for (int k = 0; k < 4; k++) begin
        resolve_br(1'b1, 1'b0, 32'h500);
        exp_bc++;
        pc = 32'h100 + 32'(r) * 32'h10 + 32'(k) * 4;
        tests++; if ({bht_en, waddr, flush} !== {1'b1, pc[4:0], 1'b0}) begin
          fails++; $display("FAIL wrap_order r%0d k%0d got en=%0b addr=%h fl=%0b exp en=1 addr=%h fl=0", r, k, bht_en, waddr, flush, pc[4:0]);
        end
      end
      tests++; if (queue_full !== 1'b0) begin fails++; $display("FAIL wrap_drain r%0d got %0b exp 0", r, queue_full); end
    end
    tests++; if (bc !== exp_bc) begin fails++; $display("FAIL wrap_bc got %0d exp %0d", bc, exp_bc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int k = 0; k < 4; k++) push_br(32'h300 + 32'(k) * 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      fv = 1'b1; fb = 1'b1; fpc = 32'h340 + 32'(k) * 4; fpred = 1'b1;
      rv = 1'b1; rt = 1'b1; rtgt = 32'h600;
      @(posedge clk); #1;
      exp_bc++;
      pc = 32'h300 + 32'(k) * 4;
      tests++; if ({bht_en, queue_full, waddr} !== {2'b11, pc[4:0]}) begin
        fails++; $display("FAIL b2b_pushpop k%0d got en=%0b full=%0b addr=%h exp en=1 full=1 addr=%h", k, bht_en, queue_full, waddr, pc[4:0]);
      end
    end
    fv = 1'b0; fb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_bc++;
      pc = 32'h340 + 32'(k) * 4;
      tests++; if ({bht_en, waddr, flush} !== {1'b1, pc[4:0], 1'b0}) begin
        fails++; $display("FAIL b2b_drain k%0d got en=%0b addr=%h fl=%0b exp en=1 addr=%h fl=0", k, bht_en, waddr, flush, pc[4:0]);
      end
    end
    rv = 1'b0; rt = 1'b0;
    tests++; if (queue_full !== 1'b0) begin fails++; $display("FAIL b2b_empty got %0b exp 0", queue_full); end
    tests++; if (bc !== exp_bc) begin fails++; $display("FAIL b2b_bc got %0d exp %0d", bc, exp_bc); end
  endtask

  task automatic test_flush();
    push_br(32'h50, 1'b0);
    push_br(32'h54, 1'b1);
    push_br(32'h58, 1'b1);
    fv = 1'b1; fb = 1'b1; fpc = 32'h5C; fpred = 1'b1;
    rv = 1'b1; rt = 1'b1; rtgt = 32'h200;
    @(posedge clk); #1;
    idle();
    exp_bc++; exp_mc++;
    tests++; if ({flush, redirect, waddr} !== {1'b1, 32'h200, 5'h10}) begin
      fails++; $display("FAIL flush_a got fl=%0b rd=%h addr=%h exp fl=1 rd=200 addr=10", flush, redirect, waddr);
    end
    tests++; if (mc !== exp_mc) begin fails++; $display("FAIL flush_mc got %0d exp %0d", mc, exp_mc); end
    resolve_br(1'b1, 1'b0, 32'h0);
    tests++; if ({perr, bht_en, flush} !== 3'b100) begin
      fails++; $display("FAIL flush_empty got perr=%0b en=%0b fl=%0b exp perr=1 en=0 fl=0", perr, bht_en, flush);
    end
    tests++; if (bc !== exp_bc) begin fails++; $display("FAIL flush_bc got %0d exp %0d", bc, exp_bc); end
    push_br(32'h60, 1'b0);
    resolve_br(1'b0, 1'b1, 32'h700);
    exp_bc++; exp_mc++;
    tests++; if ({flush, jumped, was_taken, redirect, perr} !== {3'b110, 32'h700, 1'b1}) begin
      fails++; $display("FAIL flush_jump got fl=%0b j=%0b tk=%0b rd=%h perr=%0b exp fl=1 j=1 tk=0 rd=700 perr=1", flush, jumped, was_taken, redirect, perr);
    end
  endtask

  task automatic test_stall();
    push_br(32'h30, 1'b1);
    en = 1'b0; rv = 1'b1; rt = 1'b1; rtgt = 32'h900;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      tests++; if ({bht_en, bc} !== {1'b0, exp_bc}) begin
        fails++; $display("FAIL stall_hold k%0d got en=%0b bc=%0d exp en=0 bc=%0d", k, bht_en, bc, exp_bc);
      end
    end
    en = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0; rt = 1'b0;
    exp_bc++;
    tests++; if ({bht_en, waddr, bc} !== {1'b1, 5'h10, exp_bc}) begin
      fails++; $display("FAIL stall_release got en=%0b addr=%h bc=%0d exp en=1 addr=10 bc=%0d", bht_en, waddr, bc, exp_bc);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_m [3];
    logic [31:0] exp_b [3];
    exp_m = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp_b = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    force dut.o_mispredict_count = 32'hFFFF_FFFD;
    force dut.o_branch_count = 32'hFFFF_FFFE;
    #1;
    release dut.o_mispredict_count;
    release dut.o_branch_count;
    for (int k = 0; k < 3; k++) begin
      push_br(32'h70, 1'b1);
      resolve_br(1'b0, 1'b0, 32'h0);
      tests++; if ({mc, bc} !== {exp_m[k], exp_b[k]}) begin
        fails++; $display("FAIL sat k%0d got mc=%h bc=%h exp mc=%h bc=%h", k, mc, bc, exp_m[k], exp_b[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_not_taken();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
